// File: rtl/tx_resp_arbiter.sv
// tx_resp_arbiter: shares one UART transmitter between two response sources.
//   Register-file read data (one byte) and ALU results (two bytes, LSB first) are
//   captured into holding slots. The slots are served round-robin. The valid/Busy
//   handshake with the transmitter is re-issued if Busy never rises.
// Ports:
//   CLK, Reset        clock; synchronous active-high reset
//   RdData, Rd_valid  read byte and its one-cycle strobe
//   ALU_out, ALU_out_valid  two-byte ALU result and its one-cycle strobe
//   Busy              transmitter busy (high while a frame shifts out)
//   Tx_Data, Tx_Data_valid  byte to send and its one-cycle request
//   Rsp_Pending       some slot still holds unsent data
//   Drop_Err          one-cycle pulse when a strobe hits a full slot
module tx_resp_arbiter #(
  parameter int unsigned width   = 8,
  parameter int unsigned BUSY_TO = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [width-1:0]   RdData,
  input  logic               Rd_valid,
  input  logic [2*width-1:0] ALU_out,
  input  logic               ALU_out_valid,
  input  logic               Busy,
  output logic [width-1:0]   Tx_Data,
  output logic               Tx_Data_valid,
  output logic               Rsp_Pending,
  output logic               Drop_Err
);

  localparam int unsigned CntW = (BUSY_TO > 2) ? $clog2(BUSY_TO) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BUSY_TO - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitHi, StWaitLo} state_e;

  state_e             state_q, state_d;
  logic [width-1:0]   rd_data_q, rd_data_d;
  logic               rd_full_q, rd_full_d;
  logic [2*width-1:0] alu_data_q, alu_data_d;
  logic               alu_full_q, alu_full_d;
  logic               grant_alu_q, grant_alu_d;
  logic               last_alu_q, last_alu_d;
  logic               byte_sel_q, byte_sel_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [width-1:0]   tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               drop_q, drop_d;

  logic            rd_release, alu_release, grant_alu;
  logic [CntW-1:0] cnt_inc;

  always_comb begin
    state_d     = state_q;
    grant_alu_d = grant_alu_q;
    last_alu_d  = last_alu_q;
    byte_sel_d  = byte_sel_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    rd_release  = 1'b0;
    alu_release = 1'b0;
    grant_alu   = 1'b0;
    cnt_inc     = cnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (!Busy && (rd_full_q || alu_full_q)) begin
          // With both slots full, serve whichever was not granted last.
          grant_alu   = alu_full_q && (!rd_full_q || !last_alu_q);
          grant_alu_d = grant_alu;
          last_alu_d  = grant_alu;
          tx_data_d   = grant_alu ? alu_data_q[width-1:0] : rd_data_q;
          byte_sel_d  = 1'b0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        // Registered request: visible for the cycle after this state.
        tx_valid_d = 1'b1;
        cnt_d      = '0;
        state_d    = StWaitHi;
      end
      StWaitHi: begin
        if (Busy) begin
          state_d = StWaitLo;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntMax) begin
            state_d = StIssue;
          end
        end
      end
      StWaitLo: begin
        if (!Busy) begin
          if (!grant_alu_q) begin
            rd_release = 1'b1;
            state_d    = StIdle;
          end else if (!byte_sel_q) begin
            // Upper ALU byte follows directly; RD cannot slip in between.
            tx_data_d  = alu_data_q[2*width-1:width];
            byte_sel_d = 1'b1;
            state_d    = StIssue;
          end else begin
            alu_release = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Slot capture: a slot freed on the same edge as a strobe accepts the new data.
  always_comb begin
    rd_full_d  = rd_full_q;
    rd_data_d  = rd_data_q;
    alu_full_d = alu_full_q;
    alu_data_d = alu_data_q;
    drop_d     = 1'b0;

    if (rd_release) begin
      rd_full_d = 1'b0;
    end
    if (Rd_valid) begin
      if (!rd_full_q || rd_release) begin
        rd_full_d = 1'b1;
        rd_data_d = RdData;
      end else begin
        drop_d = 1'b1;
      end
    end

    if (alu_release) begin
      alu_full_d = 1'b0;
    end
    if (ALU_out_valid) begin
      if (!alu_full_q || alu_release) begin
        alu_full_d = 1'b1;
        alu_data_d = ALU_out;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= StIdle;
      rd_data_q   <= '0;
      rd_full_q   <= 1'b0;
      alu_data_q  <= '0;
      alu_full_q  <= 1'b0;
      grant_alu_q <= 1'b0;
      last_alu_q  <= 1'b1;
      byte_sel_q  <= 1'b0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_data_q   <= rd_data_d;
      rd_full_q   <= rd_full_d;
      alu_data_q  <= alu_data_d;
      alu_full_q  <= alu_full_d;
      grant_alu_q <= grant_alu_d;
      last_alu_q  <= last_alu_d;
      byte_sel_q  <= byte_sel_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      drop_q      <= drop_d;
    end
  end

  assign Tx_Data       = tx_data_q;
  assign Tx_Data_valid = tx_valid_q;
  assign Rsp_Pending   = rd_full_q | alu_full_q;
  assign Drop_Err      = drop_q;

endmodule
